// File: rtl/es_ctrl_pkg.sv
// Shared encodings for the expression-stack sequencer: command opcodes,
// pop-count selector and the FSM state set.
package es_ctrl_pkg;

  // ESOp command encodings
  localparam logic [1:0] ES_NOP  = 2'b00;
  localparam logic [1:0] ES_PUSH = 2'b01;
  localparam logic [1:0] ES_POP  = 2'b10;
  localparam logic [1:0] ES_DUP  = 2'b11;

  // popAmt encodings
  localparam logic POP_ONE = 1'b0;
  localparam logic POP_TWO = 1'b1;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH    = 3'd1,
    S_POP_A   = 3'd2,
    S_POP_B   = 3'd3,
    S_POP_END = 3'd4,
    S_DUP_RD  = 3'd5,
    S_DUP_WR  = 3'd6
  } es_state_t;

endpackage

// File: rtl/es_pointer.sv
// Stack pointer for the expression stack: occupancy register with
// inc1/dec1/dec2 controls, empty/full flags, and the command bounds check.
// Optional feature macro: ES_BOUNDS_CHECK_EN (compiles in the reject logic;
// without it reject is tied low and sp simply wraps modulo 2*DEPTH).
module es_pointer
  import es_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc1,
  input  logic        dec1,
  input  logic        dec2,
  input  logic [1:0]  chk_op,
  input  logic        chk_pop_two,
  input  logic [1:0]  chk_dup_num,
  output logic [AW:0] sp,
  output logic        es_empty,
  output logic        es_full,
  output logic        reject
);

  localparam logic [AW:0] SP_ONE   = (AW+1)'(1);
  localparam logic [AW:0] SP_TWO   = (AW+1)'(2);
  localparam logic [AW:0] SP_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0] sp_reg;

  // Occupancy register; at most one adjustment per cycle from the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg <= '0;
    end else if (inc1) begin
      sp_reg <= sp_reg + SP_ONE;
    end else if (dec1) begin
      sp_reg <= sp_reg - SP_ONE;
    end else if (dec2) begin
      sp_reg <= sp_reg - SP_TWO;
    end
  end

  assign sp       = sp_reg;
  assign es_empty = (sp_reg == '0);
  assign es_full  = (sp_reg == SP_DEPTH);

`ifdef ES_BOUNDS_CHECK_EN
  logic [AW:0] pop_cnt;
  logic [AW:0] dup_ext;

  assign pop_cnt = (chk_pop_two == POP_TWO) ? SP_TWO : SP_ONE;
  assign dup_ext = {{(AW-1){1'b0}}, chk_dup_num};

  // Reject commands that would overrun or underrun the stack
  always_comb begin
    reject = 1'b0;
    case (chk_op)
      ES_PUSH: reject = es_full;
      ES_POP:  reject = (pop_cnt > sp_reg);
      ES_DUP:  reject = es_full || (dup_ext >= sp_reg);
      default: reject = 1'b0;
    endcase
  end
`else
  logic chk_unused;
  assign chk_unused = ^{chk_op, chk_pop_two, chk_dup_num};
  assign reject     = 1'b0;
`endif

endmodule

// File: rtl/es_stack_ctrl.sv
// Expression-stack sequencer: turns PUSH/POP/DUP commands into single-port
// stack RAM accesses (1-cycle read latency) and holds the popped operands.
// Optional feature macro: ES_BOUNDS_CHECK_EN (reject out-of-range commands
// and raise a sticky es_err; otherwise es_err is tied low).
module es_stack_ctrl
  import es_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ESAct,
  input  logic [1:0]        ESOp,
  input  logic              popAmt,
  input  logic [1:0]        dupNum,
  input  logic [DATA_W-1:0] push_data,
  output logic              es_ready,
  output logic              es_done,
  output logic [DATA_W-1:0] pop_a,
  output logic [DATA_W-1:0] pop_b,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [AW:0]       sp,
  output logic              es_empty,
  output logic              es_full,
  output logic              es_err
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_TWO = AW'(2);

  es_state_t         state_reg, state_next;
  logic [1:0]        op_reg;
  logic              pop_two_reg;
  logic [1:0]        dup_num_reg;
  logic [DATA_W-1:0] push_data_reg;
  logic [DATA_W-1:0] pop_a_reg, pop_b_reg;

  logic              accept;
  logic              reject;
  logic              inc1, dec1, dec2;
  logic [AW-1:0]     sp_addr;
  logic [AW-1:0]     dup_ext;

  es_pointer #(.DEPTH(DEPTH), .AW(AW)) u_pointer (
    .clk         (CLK),
    .rst         (Reset),
    .inc1        (inc1),
    .dec1        (dec1),
    .dec2        (dec2),
    .chk_op      (ESOp),
    .chk_pop_two (popAmt),
    .chk_dup_num (dupNum),
    .sp          (sp),
    .es_empty    (es_empty),
    .es_full     (es_full),
    .reject      (reject)
  );

  assign accept  = ESAct && (state_reg == S_IDLE);
  assign sp_addr = sp[AW-1:0];
  assign dup_ext = {{(AW-2){1'b0}}, dup_num_reg};

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Latch the command at accept; a rejected command is demoted to a NOP
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      op_reg        <= ES_NOP;
      pop_two_reg   <= POP_ONE;
      dup_num_reg   <= '0;
      push_data_reg <= '0;
    end else if (accept) begin
      op_reg        <= reject ? ES_NOP : ESOp;
      pop_two_reg   <= popAmt;
      dup_num_reg   <= dupNum;
      push_data_reg <= push_data;
    end
  end

  // Capture RAM read data into the operand registers during a POP
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pop_a_reg <= '0;
      pop_b_reg <= '0;
    end else if (state_reg == S_POP_B) begin
      pop_a_reg <= ram_rdata;
    end else if (state_reg == S_POP_END && op_reg == ES_POP) begin
      if (pop_two_reg == POP_TWO) pop_b_reg <= ram_rdata;
      else                        pop_a_reg <= ram_rdata;
    end
  end

  assign pop_a = pop_a_reg;
  assign pop_b = pop_b_reg;

  // Next state plus RAM drive and pointer controls, all decoded from state
  always_comb begin
    state_next = state_reg;
    es_ready   = 1'b0;
    es_done    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    inc1       = 1'b0;
    dec1       = 1'b0;
    dec2       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        es_ready = 1'b1;
        if (ESAct) begin
          if (reject) begin
            state_next = S_POP_END;
          end else begin
            case (ESOp)
              ES_PUSH: state_next = S_PUSH;
              ES_POP:  state_next = S_POP_A;
              ES_DUP:  state_next = S_DUP_RD;
              default: state_next = S_POP_END;
            endcase
          end
        end
      end
      S_PUSH: begin
        es_done    = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = sp_addr;
        ram_wdata  = push_data_reg;
        inc1       = 1'b1;
        state_next = S_IDLE;
      end
      S_POP_A: begin
        ram_addr   = sp_addr - ADDR_ONE;
        state_next = (pop_two_reg == POP_TWO) ? S_POP_B : S_POP_END;
      end
      S_POP_B: begin
        ram_addr   = sp_addr - ADDR_TWO;
        state_next = S_POP_END;
      end
      S_POP_END: begin
        es_done = 1'b1;
        if (op_reg == ES_POP) begin
          if (pop_two_reg == POP_TWO) dec2 = 1'b1;
          else                        dec1 = 1'b1;
        end
        state_next = S_IDLE;
      end
      S_DUP_RD: begin
        ram_addr   = sp_addr - ADDR_ONE - dup_ext;
        state_next = S_DUP_WR;
      end
      S_DUP_WR: begin
        es_done    = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = sp_addr;
        ram_wdata  = ram_rdata;
        inc1       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef ES_BOUNDS_CHECK_EN
  logic err_reg;

  // Sticky bounds error, cleared only by reset
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                 err_reg <= 1'b0;
    else if (accept && reject) err_reg <= 1'b1;
  end

  assign es_err = err_reg;
`else
  assign es_err = 1'b0;
`endif

endmodule

// File: tb/tb_es_stack_ctrl.sv
// Self-checking bench for es_stack_ctrl with a behavioural stack RAM and a
// queue-based reference model of the expression stack.
module tb_es_stack_ctrl;
  import es_ctrl_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              ESAct = 1'b0;
  logic [1:0]        ESOp = 2'b00;
  logic              popAmt = 1'b0;
  logic [1:0]        dupNum = 2'b00;
  logic [DATA_W-1:0] push_data = '0;
  logic              es_ready, es_done, ram_we, es_empty, es_full, es_err;
  logic [DATA_W-1:0] pop_a, pop_b, ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [AW-1:0]     ram_addr;
  logic [AW:0]       sp;

  es_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .Reset(Reset), .ESAct(ESAct), .ESOp(ESOp), .popAmt(popAmt),
    .dupNum(dupNum), .push_data(push_data), .es_ready(es_ready), .es_done(es_done),
    .pop_a(pop_a), .pop_b(pop_b), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sp(sp), .es_empty(es_empty),
    .es_full(es_full), .es_err(es_err)
  );

  always #5 CLK = ~CLK;

  // Single-port stack RAM, 1-cycle registered read
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_pa = '0;
  logic [DATA_W-1:0] m_pb = '0;
  logic              m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sp"},    32'(sp),       32'(q.size()));
    check({tag, "_empty"}, 32'(es_empty), 32'(q.size() == 0));
    check({tag, "_full"},  32'(es_full),  32'(q.size() == DEPTH));
    check({tag, "_pop_a"}, 32'(pop_a),    32'(m_pa));
    check({tag, "_pop_b"}, 32'(pop_b),    32'(m_pb));
    check({tag, "_err"},   32'(es_err),   32'(m_err));
    check({tag, "_ready"}, 32'(es_ready), 32'd1);
    for (int i = 0; i < q.size(); i++)
      check({tag, "_ram"}, 32'(mem[i]), 32'(q[i]));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    q.delete();
    m_pa = '0; m_pb = '0; m_err = 1'b0;
    @(negedge CLK);
  endtask

  // Issue one command from a negedge, measure latency and RAM writes, update model
  task automatic cmd(input string tag, input logic [1:0] op, input logic pa,
                     input logic [1:0] dn, input logic [DATA_W-1:0] d);
    int n, lat, we_cnt, exp_lat, exp_we, idx;
    logic rej;
    rej = 1'b0;
`ifdef ES_BOUNDS_CHECK_EN
    case (op)
      ES_PUSH: rej = (q.size() == DEPTH);
      ES_POP:  rej = ((pa ? 2 : 1) > q.size());
      ES_DUP:  rej = (q.size() == DEPTH) || (int'(dn) >= q.size());
      default: rej = 1'b0;
    endcase
`endif
    n = 0;
    while (!es_ready && n < 20) begin @(negedge CLK); n++; end
    check({tag, "_accept_ready"}, 32'(es_ready), 32'd1);
    ESAct = 1'b1; ESOp = op; popAmt = pa; dupNum = dn; push_data = d;
    @(negedge CLK);
    ESAct = 1'b0; ESOp = ES_NOP; push_data = DATA_W'($urandom);
    lat = 1; we_cnt = int'(ram_we);
    while (!es_done && lat < 10) begin
      @(negedge CLK); lat++; we_cnt += int'(ram_we);
    end
    @(negedge CLK);
    exp_lat = 1; exp_we = 0;
    if (rej) begin
      m_err = 1'b1;
    end else begin
      case (op)
        ES_PUSH: begin exp_we = 1; q.push_back(d); end
        ES_POP: begin
          exp_lat = pa ? 3 : 2;
          m_pa = q.pop_back();
          if (pa) m_pb = q.pop_back();
        end
        ES_DUP: begin
          exp_lat = 2; exp_we = 1;
          idx = q.size() - 1 - int'(dn);
          q.push_back(q[idx]);
        end
        default: ;
      endcase
    end
    $display("cmd %s op=%0d pa=%0d dn=%0d data=%0h lat=%0d sp=%0d pop_a=%0h pop_b=%0h err=%0d",
             tag, op, pa, dn, d, lat, sp, pop_a, pop_b, es_err);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ram_we"}, 32'(we_cnt), 32'(exp_we));
    check_state(tag);
  endtask

  initial begin
    int sz, r;
    logic [1:0] dn;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_done", 32'(es_done), 32'd0);
    check("rst_pop_a", 32'(pop_a), 32'd0);
    check("rst_err", 32'(es_err), 32'd0);
    Reset = 1'b0;
    @(negedge CLK);
    check("rst_release_we", 32'(ram_we), 32'd0);

    // Pushes, 2-entry pop, DUPs
    cmd("push5", ES_PUSH, 1'b0, 2'd0, 16'h0005);
    cmd("push7", ES_PUSH, 1'b0, 2'd0, 16'h0007);
    cmd("pop2", ES_POP, 1'b1, 2'd0, 16'h0000);
    cmd("pushA", ES_PUSH, 1'b0, 2'd0, 16'h000A);
    cmd("pushB", ES_PUSH, 1'b0, 2'd0, 16'h000B);
    cmd("pushC", ES_PUSH, 1'b0, 2'd0, 16'h000C);
    cmd("dup2", ES_DUP, 1'b0, 2'd2, 16'h0000);
    cmd("dup0", ES_DUP, 1'b0, 2'd0, 16'h0000);
    cmd("nop", ES_NOP, 1'b0, 2'd0, 16'hFFFF);
    cmd("pop1", ES_POP, 1'b0, 2'd0, 16'h0000);

    // Reset in the middle of POP_B
    ESAct = 1'b1; ESOp = ES_POP; popAmt = 1'b1;
    @(negedge CLK);
    ESAct = 1'b0; ESOp = ES_NOP;
    @(negedge CLK);
    check("popb_addr", 32'(ram_addr), 32'(q.size() - 2));
    Reset = 1'b1;
    #1;
    check("mid_rst_sp", 32'(sp), 32'd0);
    check("mid_rst_pop_a", 32'(pop_a), 32'd0);
    check("mid_rst_pop_b", 32'(pop_b), 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_we", 32'(ram_we), 32'd0);
    check("mid_rst_done", 32'(es_done), 32'd0);
    check("mid_rst_err", 32'(es_err), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    q.delete(); m_pa = '0; m_pb = '0; m_err = 1'b0;
    @(negedge CLK);
    check("post_rst_we", 32'(ram_we), 32'd0);
    cmd("push1234", ES_PUSH, 1'b0, 2'd0, 16'h1234);

    // Back-to-back pushes with ESAct held high
    do_reset();
    ESAct = 1'b1; ESOp = ES_PUSH; popAmt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      push_data = 16'(c / 2 + 1);
      check("b2b_ready", 32'(es_ready), 32'(c % 2 == 0));
      check("b2b_done", 32'(es_done), 32'(c % 2 == 1));
      @(negedge CLK);
    end
    ESAct = 1'b0; ESOp = ES_NOP;
    for (int k = 1; k <= 4; k++) q.push_back(16'(k));
    $display("cmd b2b_push pushes=4 sp=%0d", sp);
    check_state("b2b");

    // Randomized in-bounds commands
    do_reset();
    for (int i = 0; i < 60; i++) begin
      sz = q.size();
      r = int'($urandom_range(0, 3));
      if (r == 1 && sz < DEPTH) begin
        cmd("rnd_push", ES_PUSH, 1'b0, 2'd0, DATA_W'($urandom));
      end else if (r == 2 && sz >= 1) begin
        cmd("rnd_pop", ES_POP, (sz >= 2) ? 1'($urandom_range(0, 1)) : 1'b0, 2'd0, 16'h0);
      end else if (r == 3 && sz >= 1 && sz < DEPTH) begin
        dn = 2'($urandom_range(0, (sz - 1 < 3) ? sz - 1 : 3));
        cmd("rnd_dup", ES_DUP, 1'b0, dn, 16'h0);
      end else begin
        cmd("rnd_nop", ES_NOP, 1'b0, 2'd0, DATA_W'($urandom));
      end
    end

`ifdef ES_BOUNDS_CHECK_EN
    // Bounds rejections
    do_reset();
    cmd("bnd_pop_empty", ES_POP, 1'b0, 2'd0, 16'h0);
    do_reset();
    cmd("bnd_push_first", ES_PUSH, 1'b0, 2'd0, 16'h0042);
    cmd("bnd_pop2_one", ES_POP, 1'b1, 2'd0, 16'h0);
    cmd("bnd_dup_deep", ES_DUP, 1'b0, 2'd1, 16'h0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cmd("bnd_fill", ES_PUSH, 1'b0, 2'd0, 16'(i + 16'h0100));
    cmd("bnd_push_full", ES_PUSH, 1'b0, 2'd0, 16'hDEAD);
    cmd("bnd_dup_full", ES_DUP, 1'b0, 2'd0, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
